// File: rtl/mac_ctrl_pkg.sv
// MAC job controller shared types.
// State encoding and default datapath sizes.
package mac_ctrl_pkg;

  localparam int DW_DEF      = 2;
  localparam int SW_DEF      = 4;
  localparam int LENW_DEF    = 4;
  localparam int MAC_LAT_DEF = 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    RESULT
  } state_t;

endpackage

// File: rtl/mac_job_ctrl_if.sv
// Bundle of job, operand, MAC and result signals.
// slave = controller side, master = environment side.
interface mac_job_ctrl_if
  import mac_ctrl_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int SW   = SW_DEF,
  parameter int LENW = LENW_DEF
);

  logic            start;
  logic [LENW-1:0] len;
  logic            abort;
  logic            busy;
  logic            op_valid;
  logic [DW-1:0]   op_a;
  logic [DW-1:0]   op_b;
  logic            op_ready;
  logic [DW-1:0]   mac_a;
  logic [DW-1:0]   mac_b;
  logic            mac_e;
  logic [SW-1:0]   mac_sum;
  logic            res_valid;
  logic [SW-1:0]   res_data;
  logic            res_ready;

  modport slave (
    input  start,
    input  len,
    input  abort,
    output busy,
    input  op_valid,
    input  op_a,
    input  op_b,
    output op_ready,
    output mac_a,
    output mac_b,
    output mac_e,
    input  mac_sum,
    output res_valid,
    output res_data,
    input  res_ready
  );

  modport master (
    output start,
    output len,
    output abort,
    input  busy,
    output op_valid,
    output op_a,
    output op_b,
    input  op_ready,
    input  mac_a,
    input  mac_b,
    input  mac_e,
    output mac_sum,
    input  res_valid,
    input  res_data,
    output res_ready
  );

endinterface

// File: rtl/mac_job_ctrl_drain.sv
// Drain down-counter: loads MAC_LAT, flags zero.
// Covers the MAC pipeline before the sum is captured.
module mac_drain_timer #(
  parameter int MAC_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int TW = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

  logic [TW-1:0] cnt;

  // Count down from MAC_LAT while enabled, park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TW'(MAC_LAT);
    end else if (en && cnt != '0) begin
      cnt <= cnt - TW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mac_job_ctrl.sv
// Job sequencer for the shared 2x2-bit MAC.
// Clears, feeds N pairs, drains, presents the sum.
module mac_job_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int SW      = SW_DEF,
  parameter int LENW    = LENW_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input logic           clk,
  input logic           rst,
  mac_job_ctrl_if.slave bus
);

  state_t          state;
  logic [LENW-1:0] len_q;
  logic [LENW-1:0] count;
  logic            hs;
  logic            last_hs;
  logic            kill;
  logic            tmr_load;
  logic            tmr_clr;
  logic            tmr_en;
  logic            tmr_zero;

  assign hs       = (state == FEED) && bus.op_valid
                    && bus.op_ready;
  assign last_hs  = hs && (count == len_q - LENW'(1));
  assign kill     = bus.abort && (state != IDLE);
  assign tmr_clr  = kill;
  assign tmr_load = last_hs && !bus.abort;
  assign tmr_en   = (state == DRAIN);

  mac_drain_timer #(
    .MAC_LAT(MAC_LAT)
  ) u_drain (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmr_clr),
    .load (tmr_load),
    .en   (tmr_en),
    .zero (tmr_zero)
  );

  // Job FSM with every output registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      len_q         <= '0;
      count         <= '0;
      bus.busy      <= 1'b0;
      bus.op_ready  <= 1'b0;
      bus.mac_a     <= '0;
      bus.mac_b     <= '0;
      bus.mac_e     <= 1'b1;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
    end else if (kill) begin
      state         <= IDLE;
      count         <= '0;
      bus.busy      <= 1'b0;
      bus.op_ready  <= 1'b0;
      bus.mac_a     <= '0;
      bus.mac_b     <= '0;
      bus.mac_e     <= 1'b1;
      bus.res_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          bus.mac_e    <= 1'b1;
          bus.mac_a    <= '0;
          bus.mac_b    <= '0;
          bus.op_ready <= 1'b0;
          if (bus.start && !bus.abort) begin
            bus.busy <= 1'b1;
            if (bus.len != '0) begin
              len_q <= bus.len;
              count <= '0;
              state <= CLEAR;
            end else begin
              bus.res_data  <= '0;
              bus.res_valid <= 1'b1;
              state         <= RESULT;
            end
          end
        end
        CLEAR: begin
          bus.mac_e    <= 1'b0;
          bus.mac_a    <= '0;
          bus.mac_b    <= '0;
          bus.op_ready <= 1'b1;
          state        <= FEED;
        end
        FEED: begin
          if (hs) begin
            bus.mac_a <= bus.op_a;
            bus.mac_b <= bus.op_b;
            if (last_hs) begin
              count        <= '0;
              bus.op_ready <= 1'b0;
              state        <= DRAIN;
            end else begin
              count <= count + LENW'(1);
            end
          end else begin
            bus.mac_a <= '0;
            bus.mac_b <= '0;
          end
        end
        DRAIN: begin
          bus.mac_a <= '0;
          bus.mac_b <= '0;
          if (tmr_zero) begin
            bus.res_data  <= bus.mac_sum;
            bus.res_valid <= 1'b1;
            state         <= RESULT;
          end
        end
        RESULT: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.mac_e     <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_job_ctrl.sv
// Self-checking bench for mac_job_ctrl.
// Behavioural MAC plus expected-sum scoreboard.
module tb_mac_job_ctrl;
  import mac_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mac_job_ctrl_if bus ();

  mac_job_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // MAC: E clears, otherwise adds a*b modulo 16.
  logic [3:0] acc = 4'h0;
  always @(posedge clk) begin
    if (bus.mac_e) acc <= 4'h0;
    else acc <= acc + ({2'b00, bus.mac_a} * {2'b00, bus.mac_b});
  end
  assign bus.mac_sum = acc;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];
  int pa[8];
  int pb[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] model_sum(input int n);
    int s;
    s = 0;
    for (int i = 0; i < n; i++) s += pa[i] * pb[i];
    return 4'(s % 16);
  endfunction

  task automatic start_job(input int n);
    bus.len = 4'(n);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic feed(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      bit hs;
      int guard;
      logic [1:0] ea;
      logic [1:0] eb;
      ea = 2'(pa[i]);
      eb = 2'(pb[i]);
      bus.op_valid = 1'b1;
      bus.op_a = ea;
      bus.op_b = eb;
      hs = 1'b0;
      guard = 0;
      while (!hs && guard < 20) begin
        hs = bus.op_ready;
        tick();
        guard++;
      end
      bus.op_valid = 1'b0;
      checks++;
      if (!hs) begin
        $display("FAIL feed_timeout pair %0d", i);
        errors++;
      end
      checks++;
      if (bus.mac_a !== ea || bus.mac_b !== eb) begin
        $display("FAIL mac_operands got %0d,%0d want %0d,%0d",
                 bus.mac_a, bus.mac_b, ea, eb);
        errors++;
      end
      if (i < n - 1) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          checks++;
          if (bus.mac_a !== 2'd0 || bus.mac_b !== 2'd0
              || bus.mac_e !== 1'b0) begin
            $display("FAIL bubble got a=%0d b=%0d e=%0d want 0,0,0",
                     bus.mac_a, bus.mac_b, bus.mac_e);
            errors++;
          end
        end
      end
    end
  endtask

  task automatic wait_result(input int lat, output logic [3:0] ex);
    int cnt;
    cnt = 0;
    while (!bus.res_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    checks++;
    if (cnt !== lat) begin
      $display("FAIL result_latency got %0d want %0d", cnt, lat);
      errors++;
    end
    ex = 4'h0;
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard_empty got result %0h", bus.res_data);
      errors++;
    end else begin
      ex = exp_q.pop_front();
      if (bus.res_data !== ex) begin
        $display("FAIL res_data got %0h want %0h", bus.res_data, ex);
        errors++;
      end
    end
  endtask

  task automatic accept();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      $display("FAIL accept got valid=%0b busy=%0b want 0,0",
               bus.res_valid, bus.busy);
      errors++;
    end
  endtask

  task automatic run_job(input int n, input int gap);
    logic [3:0] ex;
    exp_q.push_back(model_sum(n));
    start_job(n);
    feed(n, gap);
    wait_result(MAC_LAT_DEF + 1, ex);
    accept();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.op_ready !== 1'b0
        || bus.mac_e !== 1'b1 || bus.res_valid !== 1'b0
        || bus.res_data !== 4'h0 || bus.mac_a !== 2'd0
        || bus.mac_b !== 2'd0) begin
      $display("FAIL reset_values busy=%0b rdy=%0b e=%0b v=%0b d=%0h",
               bus.busy, bus.op_ready, bus.mac_e,
               bus.res_valid, bus.res_data);
      errors++;
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    pa[0] = 1; pb[0] = 1;
    pa[1] = 1; pb[1] = 2;
    pa[2] = 3; pb[2] = 3;
    run_job(3, 0);
  endtask

  task automatic test_bubbles();
    pa[0] = 1; pb[0] = 1;
    pa[1] = 1; pb[1] = 2;
    pa[2] = 3; pb[2] = 3;
    run_job(3, 2);
  endtask

  task automatic test_wrap();
    pa[0] = 3; pb[0] = 3;
    pa[1] = 3; pb[1] = 3;
    run_job(2, 0);
  endtask

  task automatic test_backpressure();
    logic [3:0] ex;
    pa[0] = 1; pb[0] = 3;
    exp_q.push_back(model_sum(1));
    start_job(1);
    feed(1, 0);
    wait_result(MAC_LAT_DEF + 1, ex);
    for (int k = 0; k < 5; k++) begin
      bus.len = 4'd2;
      bus.start = (k == 1);
      tick();
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== ex
          || bus.busy !== 1'b1) begin
        $display("FAIL hold got v=%0b d=%0h busy=%0b want 1,%0h,1",
                 bus.res_valid, bus.res_data, bus.busy, ex);
        errors++;
      end
    end
    bus.start = 1'b0;
    accept();
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.mac_e !== 1'b1) begin
      $display("FAIL start_not_queued got busy=%0b e=%0b want 0,1",
               bus.busy, bus.mac_e);
      errors++;
    end
  endtask

  task automatic test_zero_len();
    logic [3:0] ex;
    exp_q.push_back(4'h0);
    bus.len = 4'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b1 || bus.busy !== 1'b1
        || bus.op_ready !== 1'b0 || bus.mac_e !== 1'b1) begin
      $display("FAIL zero_len got v=%0b busy=%0b rdy=%0b e=%0b",
               bus.res_valid, bus.busy, bus.op_ready, bus.mac_e);
      errors++;
    end
    wait_result(0, ex);
    accept();
  endtask

  task automatic test_abort();
    pa[0] = 3; pb[0] = 3;
    start_job(3);
    feed(1, 0);
    bus.op_valid = 1'b1;
    bus.op_a = 2'd2;
    bus.op_b = 2'd2;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.op_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.op_ready !== 1'b0
        || bus.mac_e !== 1'b1 || bus.res_valid !== 1'b0
        || bus.mac_a !== 2'd0) begin
      $display("FAIL abort got busy=%0b rdy=%0b e=%0b v=%0b a=%0d",
               bus.busy, bus.op_ready, bus.mac_e,
               bus.res_valid, bus.mac_a);
      errors++;
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
        $display("FAIL abort_idle got v=%0b busy=%0b want 0,0",
                 bus.res_valid, bus.busy);
        errors++;
      end
    end
    bus.len = 4'd2;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      $display("FAIL abort_with_start got busy=%0b want 0", bus.busy);
      errors++;
    end
    pa[0] = 2; pb[0] = 1;
    run_job(1, 0);
  endtask

  task automatic test_reset_mid_feed();
    pa[0] = 1; pb[0] = 2;
    start_job(3);
    feed(1, 0);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.op_ready !== 1'b0
        || bus.mac_e !== 1'b1 || bus.mac_a !== 2'd0
        || bus.mac_b !== 2'd0 || bus.res_valid !== 1'b0) begin
      $display("FAIL async_reset got busy=%0b rdy=%0b e=%0b a=%0d",
               bus.busy, bus.op_ready, bus.mac_e, bus.mac_a);
      errors++;
    end
    #2;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
        $display("FAIL post_reset got v=%0b busy=%0b want 0,0",
                 bus.res_valid, bus.busy);
        errors++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.len = 4'd0;
    bus.abort = 1'b0;
    bus.op_valid = 1'b0;
    bus.op_a = 2'd0;
    bus.op_b = 2'd0;
    bus.res_ready = 1'b0;
    test_reset();
    test_basic();
    test_bubbles();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_abort();
    test_reset_mid_feed();
    checks++;
    if (exp_q.size() !== 0) begin
      $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
      errors++;
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
